axil_ram_ctrl: RTL and testbench



---
 rtl/axil_ram_ctrl.sv | 164 ++++++++++++++++
 tb/tb_axil_ram_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_ram_ctrl.sv
// AXI4-Lite slave front end for the single-clock RAM block (separate wr/rd ports,
// byte enables, 1-cycle registered read). Write and read channels run independently.
module axil_ram_ctrl #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] s_awaddr,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [DATA_WIDTH-1:0] s_wdata,
  input  logic [STRB_WIDTH-1:0] s_wstrb,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [ADDR_WIDTH-1:0] s_araddr,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [DATA_WIDTH-1:0] s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic [ADDR_WIDTH-1:0] mem_wr_addr,
  output logic [ADDR_WIDTH-1:0] mem_rd_addr,
  output logic                  mem_wr,
  output logic                  mem_rd,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic [STRB_WIDTH-1:0] mem_be,
  output logic                  mem_cs,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  localparam int OFFS = $clog2(STRB_WIDTH);

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_MEM  = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_MEM  = 2'd1;
  localparam logic [1:0] R_CAP  = 2'd2;
  localparam logic [1:0] R_RESP = 2'd3;

  function automatic logic [ADDR_WIDTH-1:0] word_addr(input logic [ADDR_WIDTH-1:0] byte_addr);
    return byte_addr >> OFFS;
  endfunction

  logic [1:0]            w_state;
  logic                  aw_held;
  logic                  w_held;
  logic [ADDR_WIDTH-1:0] aw_addr_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic [STRB_WIDTH-1:0] w_strb_q;
  logic                  aw_hs;
  logic                  w_hs;
  logic [ADDR_WIDTH-1:0] aw_addr_sel;
  logic [DATA_WIDTH-1:0] w_data_sel;
  logic [STRB_WIDTH-1:0] w_strb_sel;

  logic [1:0]            r_state;
  logic                  ar_hs;

  // Readies are gated by rst so nothing is offered while reset is held,
  // yet the first handshake can land on the first edge after release.
  assign s_awready = !rst && (w_state == W_IDLE) && !aw_held;
  assign s_wready  = !rst && (w_state == W_IDLE) && !w_held;
  assign s_arready = !rst && (r_state == R_IDLE);

  assign aw_hs = s_awvalid && s_awready;
  assign w_hs  = s_wvalid && s_wready;
  assign ar_hs = s_arvalid && s_arready;

  assign s_bvalid = (w_state == W_RESP);
  assign s_bresp  = 2'b00;
  assign s_rvalid = (r_state == R_RESP);
  assign s_rresp  = 2'b00;

  assign mem_wr = (w_state == W_MEM);
  assign mem_rd = (r_state == R_MEM);
  assign mem_cs = mem_wr | mem_rd;

  // A channel arriving this very cycle bypasses its latch.
  always_comb begin
    aw_addr_sel = aw_held ? aw_addr_q : s_awaddr;
    w_data_sel  = w_held ? w_data_q : s_wdata;
    w_strb_sel  = w_held ? w_strb_q : s_wstrb;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_state     <= W_IDLE;
      aw_held     <= 1'b0;
      w_held      <= 1'b0;
      aw_addr_q   <= '0;
      w_data_q    <= '0;
      w_strb_q    <= '0;
      mem_wr_addr <= '0;
      mem_wr_data <= '0;
      mem_be      <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            aw_held   <= 1'b1;
            aw_addr_q <= s_awaddr;
          end
          if (w_hs) begin
            w_held   <= 1'b1;
            w_data_q <= s_wdata;
            w_strb_q <= s_wstrb;
          end
          // RAM port registers only change on entry to W_MEM so they hold otherwise.
          if ((aw_held || aw_hs) && (w_held || w_hs)) begin
            w_state     <= W_MEM;
            mem_wr_addr <= word_addr(aw_addr_sel);
            mem_wr_data <= w_data_sel;
            mem_be      <= w_strb_sel;
          end
        end
        W_MEM: w_state <= W_RESP;
        W_RESP: begin
          if (s_bready) begin
            w_state <= W_IDLE;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // RAM data is only valid in the cycle after mem_rd, so it is captured in R_CAP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= R_IDLE;
      mem_rd_addr <= '0;
      s_rdata     <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            mem_rd_addr <= word_addr(s_araddr);
            r_state     <= R_MEM;
          end
        end
        R_MEM: r_state <= R_CAP;
        R_CAP: begin
          s_rdata <= mem_rd_data;
          r_state <= R_RESP;
        end
        R_RESP: begin
          if (s_rready) r_state <= R_IDLE;
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axil_ram_ctrl.sv
// Scoreboard bench for axil_ram_ctrl: stimulus pushes expectations from a word-array
// model, a negedge monitor pops and compares on every DUT response and RAM strobe.
module tb_axil_ram_ctrl;

  localparam int DW = 32;
  localparam int AW = 8;
  localparam int SW = DW / 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] s_awaddr = '0;
  logic          s_awvalid = 1'b0;
  logic          s_awready;
  logic [DW-1:0] s_wdata = '0;
  logic [SW-1:0] s_wstrb = '0;
  logic          s_wvalid = 1'b0;
  logic          s_wready;
  logic [1:0]    s_bresp;
  logic          s_bvalid;
  logic          s_bready = 1'b1;
  logic [AW-1:0] s_araddr = '0;
  logic          s_arvalid = 1'b0;
  logic          s_arready;
  logic [DW-1:0] s_rdata;
  logic [1:0]    s_rresp;
  logic          s_rvalid;
  logic          s_rready = 1'b1;
  logic [AW-1:0] mem_wr_addr;
  logic [AW-1:0] mem_rd_addr;
  logic          mem_wr;
  logic          mem_rd;
  logic [DW-1:0] mem_wr_data;
  logic [SW-1:0] mem_be;
  logic          mem_cs;
  logic [DW-1:0] mem_rd_data;

  always #5 clk = ~clk;

  axil_ram_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .mem_wr_addr(mem_wr_addr), .mem_rd_addr(mem_rd_addr), .mem_wr(mem_wr), .mem_rd(mem_rd),
    .mem_wr_data(mem_wr_data), .mem_be(mem_be), .mem_cs(mem_cs), .mem_rd_data(mem_rd_data)
  );

  // RAM block model: registered read (read-before-write), X when not reading.
  logic [DW-1:0] ram [256] = '{default: '0};
  logic [DW-1:0] ram_q = '0;
  logic          rd_vld = 1'b0;
  logic [DW-1:0] ram_merged;

  always_comb begin
    ram_merged = ram[mem_wr_addr];
    for (int b = 0; b < SW; b++)
      if (mem_be[b]) ram_merged[b*8 +: 8] = mem_wr_data[b*8 +: 8];
  end

  always @(posedge clk) begin
    rd_vld <= mem_cs && mem_rd;
    if (mem_cs && mem_rd) ram_q <= ram[mem_rd_addr];
    if (mem_cs && mem_wr) ram[mem_wr_addr] <= ram_merged;
  end

  assign mem_rd_data = rd_vld ? ram_q : 'x;

  // Reference model and scoreboard
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [SW-1:0] be;
  } wr_t;

  logic [DW-1:0] ref_mem [256] = '{default: '0};
  wr_t           exp_wr[$];
  logic [AW-1:0] exp_rd_addr[$];
  logic [DW-1:0] exp_rdata[$];
  logic          exp_b[$];

  int checks = 0;
  int passes = 0;
  logic saw_both = 1'b0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic failNow(input string name);
    checks++;
    $display("[TB] FAIL %s", name);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (s_bvalid && s_bready) begin
        if (exp_b.size() == 0) failNow("unexpected bvalid");
        else begin
          void'(exp_b.pop_front());
          checkOutput("bresp", 32'(s_bresp), 32'd0);
        end
      end
      if (s_rvalid && s_rready) begin
        if (exp_rdata.size() == 0) failNow("unexpected rvalid");
        else begin
          checkOutput("rdata", s_rdata, exp_rdata.pop_front());
          checkOutput("rresp", 32'(s_rresp), 32'd0);
        end
      end
      if (mem_wr) begin
        if (exp_wr.size() == 0) failNow("unexpected mem_wr");
        else begin
          wr_t e;
          e = exp_wr.pop_front();
          checkOutput("mem_wr_addr", 32'(mem_wr_addr), 32'(e.addr));
          checkOutput("mem_wr_data", mem_wr_data, e.data);
          checkOutput("mem_be", 32'(mem_be), 32'(e.be));
        end
      end
      if (mem_rd) begin
        if (exp_rd_addr.size() == 0) failNow("unexpected mem_rd");
        else checkOutput("mem_rd_addr", 32'(mem_rd_addr), 32'(exp_rd_addr.pop_front()));
      end
      if (mem_wr || mem_rd) checkOutput("mem_cs", 32'(mem_cs), 32'd1);
      if (mem_wr && mem_rd && mem_cs) saw_both = 1'b1;
    end
  end

  // Issues one write and/or one read; expectations come from the word-array model.
  task automatic applyStimulus(input bit do_wr, input bit do_rd,
                               input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                               input logic [SW-1:0] ws, input logic [AW-1:0] ra,
                               input int aw_dly, input int w_dly);
    if (do_rd) begin
      exp_rd_addr.push_back(ra / 4);
      exp_rdata.push_back(ref_mem[ra / 4]);
    end
    if (do_wr) begin
      wr_t e;
      e.addr = wa / 4;
      e.data = wd;
      e.be   = ws;
      exp_wr.push_back(e);
      exp_b.push_back(1'b1);
      for (int b = 0; b < SW; b++)
        if (ws[b]) ref_mem[wa / 4][b*8 +: 8] = wd[b*8 +: 8];
    end
    fork
      if (do_wr) begin
        int n;
        for (int i = 0; i < aw_dly; i++) begin
          @(negedge clk);
          checkOutput("mem_wr before aw", 32'(mem_wr), 32'd0);
          @(posedge clk); #1;
        end
        s_awaddr = wa; s_awvalid = 1'b1; n = 0;
        do begin @(negedge clk); n++; end while (!s_awready && n < 50);
        if (n >= 50) failNow("awready timeout");
        @(posedge clk); #1; s_awvalid = 1'b0;
      end
      if (do_wr) begin
        int n;
        for (int i = 0; i < w_dly; i++) begin @(posedge clk); #1; end
        s_wdata = wd; s_wstrb = ws; s_wvalid = 1'b1; n = 0;
        do begin @(negedge clk); n++; end while (!s_wready && n < 50);
        if (n >= 50) failNow("wready timeout");
        @(posedge clk); #1; s_wvalid = 1'b0;
      end
      if (do_rd) begin
        int n;
        s_araddr = ra; s_arvalid = 1'b1; n = 0;
        do begin @(negedge clk); n++; end while (!s_arready && n < 50);
        if (n >= 50) failNow("arready timeout");
        @(posedge clk); #1; s_arvalid = 1'b0;
      end
    join
  endtask

  task automatic waitIdle();
    int n = 0;
    while ((exp_b.size() + exp_rdata.size() + exp_wr.size() + exp_rd_addr.size()) != 0 && n < 100) begin
      @(negedge clk); n++;
    end
    if (n >= 100) begin
      failNow("scoreboard drain timeout");
      exp_b.delete(); exp_rdata.delete(); exp_wr.delete(); exp_rd_addr.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, " ctrl"}, 32'({s_awready, s_wready, s_arready, s_bvalid, s_rvalid,
                                      mem_wr, mem_rd, mem_cs}), 32'd0);
    checkOutput({tag, " rdata"}, s_rdata, 32'd0);
    checkOutput({tag, " mem addr"}, 32'({mem_wr_addr, mem_rd_addr}), 32'd0);
  endtask

  initial begin
    logic [DW-1:0] held;
    int n;

    repeat (3) @(posedge clk);
    @(negedge clk);
    checkResetState("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // AW+W together, then read back
    applyStimulus(1, 0, 8'h08, 32'hDEADBEEF, 4'hF, 8'h00, 0, 0);
    waitIdle();
    applyStimulus(0, 1, 8'h00, 32'h0, 4'h0, 8'h08, 0, 0);
    waitIdle();

    // W three cycles ahead of AW, partial strobes
    applyStimulus(1, 0, 8'h08, 32'h11223344, 4'b0101, 8'h00, 3, 0);
    waitIdle();
    applyStimulus(0, 1, 8'h00, 32'h0, 4'h0, 8'h08, 0, 0);
    waitIdle();
    checkOutput("partial merge", ref_mem[2], 32'hDE22BE44);

    // Backpressure on both response channels
    s_bready = 1'b0; s_rready = 1'b0;
    applyStimulus(1, 1, 8'h14, 32'h0BADF00D, 4'hF, 8'h08, 0, 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!(s_bvalid && s_rvalid) && n < 20);
    if (n >= 20) failNow("valid timeout");
    held = s_rdata;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bvalid held", 32'(s_bvalid), 32'd1);
      checkOutput("rvalid held", 32'(s_rvalid), 32'd1);
      checkOutput("rdata stable", s_rdata, held);
      checkOutput("readies low", 32'({s_awready, s_wready, s_arready}), 32'd0);
    end
    @(posedge clk); #1;
    s_bready = 1'b1; s_rready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("valids after ready", 32'({s_bvalid, s_rvalid}), 32'd0);
    waitIdle();

    // W_MEM and R_MEM coincide on word 4
    saw_both = 1'b0;
    applyStimulus(1, 1, 8'h10, 32'hAAAA5555, 4'hF, 8'h10, 0, 0);
    waitIdle();
    checkOutput("concurrent strobes", 32'(saw_both), 32'd1);
    applyStimulus(0, 1, 8'h00, 32'h0, 4'h0, 8'h10, 0, 0);
    waitIdle();

    // Reset while the read sits in R_CAP
    exp_rd_addr.push_back(8'h05);
    s_araddr = 8'h14; s_arvalid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1; s_arvalid = 1'b0;
    @(posedge clk); #1; rst = 1'b1;
    @(negedge clk);
    checkResetState("mid reset");
    @(posedge clk); #1; rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("no rvalid after reset", 32'(s_rvalid), 32'd0);
    end
    @(posedge clk); #1;
    applyStimulus(0, 1, 8'h00, 32'h0, 4'h0, 8'h14, 0, 0);
    waitIdle();

    // Unaligned read address
    applyStimulus(0, 1, 8'h00, 32'h0, 4'h0, 8'h0B, 0, 0);
    waitIdle();

    // Randomized mix of writes, reads and overlapping pairs
    for (int i = 0; i < 60; i++) begin
      int op;
      logic [AW-1:0] wa, ra;
      op = $urandom_range(0, 2);
      wa = AW'({4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))});
      ra = AW'({4'($urandom_range(0, 15)), 2'($urandom_range(0, 3))});
      applyStimulus(op != 1, op != 0, wa, $urandom, 4'($urandom_range(0, 15)), ra,
                    $urandom_range(0, 3), $urandom_range(0, 3));
      waitIdle();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $display("%0d/%0d checks passed", passes, checks + 1);
    $fatal(1, "[TB] watchdog");
  end

endmodule
